dm_port_arbiter: RTL

Single-port data-memory (DM) arbiter between the load/store unit's load requests and committed stores. Committed stores enter a small write buffer so that store commit never steals the DM port in the commit cycle. The arbiter grants one DM access per cycle: either a load read or the oldest buffered write. Grants follow load-first priority, with word-address hazard blocking and a starvation bound for writes.

---
 rtl/dm_port_arbiter_pkg.sv | 22 ++
 rtl/dm_write_buffer.sv | 70 +++++++
 rtl/dm_port_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter and its write buffer.
package dm_port_arbiter_pkg;

  // Active-low bit write enable meaning "write nothing".
  localparam logic [31:0] DM_WMASK_NONE = 32'hFFFF_FFFF;

  // One buffered committed store.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic        valid;
  } wb_entry_t;

  // What the single DM port does in a given cycle.
  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_READ,
    GNT_WRITE
  } grant_e;

endpackage

// File: rtl/dm_write_buffer.sv
// Circular store buffer with wrap-bit pointers and a parallel word-address
// hazard compare against every valid entry plus the store entering this cycle.
module dm_write_buffer
  import dm_port_arbiter_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enq,
  input  logic [31:0]                 enq_addr,
  input  logic [31:0]                 enq_wdata,
  input  logic [31:0]                 enq_wmask,
  input  logic                        deq,
  input  logic [29:0]                 cmp_word,
  output logic [31:0]                 head_addr,
  output logic [31:0]                 head_wdata,
  output logic [31:0]                 head_wmask,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(WB_DEPTH):0]   count,
  output logic                        hz
);

  localparam int IW = $clog2(WB_DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  wb_entry_t     entries [WB_DEPTH];

  // Pointers advance on enqueue/dequeue and wrap naturally through the extra wrap bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (deq) head_ptr <= head_ptr + PW'(1);
      if (enq) tail_ptr <= tail_ptr + PW'(1);
    end
  end

  // Entry storage; a drained entry is cleared so it can no longer raise a hazard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WB_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (deq) entries[head_ptr[IW-1:0]] <= '0;
      if (enq) entries[tail_ptr[IW-1:0]] <= '{addr: enq_addr, wdata: enq_wdata,
                                              wmask: enq_wmask, valid: 1'b1};
    end
  end

  // Word-address compare of the load against buffered stores and the incoming store.
  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (entries[i].valid && (entries[i].addr[31:2] == cmp_word)) hz = 1'b1;
    end
    if (enq && (enq_addr[31:2] == cmp_word)) hz = 1'b1;
  end

  assign full       = (head_ptr[IW-1:0] == tail_ptr[IW-1:0]) && (head_ptr[IW] != tail_ptr[IW]);
  assign empty      = (head_ptr == tail_ptr);
  assign count      = tail_ptr - head_ptr;
  assign head_addr  = entries[head_ptr[IW-1:0]].addr;
  assign head_wdata = entries[head_ptr[IW-1:0]].wdata;
  assign head_wmask = entries[head_ptr[IW-1:0]].wmask;

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-port DM arbiter: load-first grants, buffered committed stores,
// word-address hazard blocking and a starvation bound for buffered writes.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int WB_DEPTH   = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_req_valid,
  input  logic [31:0]                 ld_req_addr,
  output logic                        ld_req_ready,
  output logic                        ld_rsp_valid,
  output logic [31:0]                 ld_rsp_data,
  input  logic                        st_valid,
  input  logic [31:0]                 st_addr,
  input  logic [31:0]                 st_wdata,
  input  logic [31:0]                 st_wmask,
  output logic                        st_ready,
  output logic                        wb_empty,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  input  logic [31:0]                 DM_rd_data,
  output logic                        DM_r_en,
  output logic [31:0]                 DM_w_en,
  output logic [31:0]                 DM_addr,
  output logic [31:0]                 DM_w_data
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic          wb_full;
  logic          hz;
  logic          enq;
  logic [31:0]   head_addr;
  logic [31:0]   head_wdata;
  logic [31:0]   head_wmask;
  logic [SW-1:0] starve;
  grant_e        grant;

  assign st_ready    = !wb_full;
  assign enq         = st_valid && st_ready;
  assign ld_rsp_data = DM_rd_data;

  dm_write_buffer #(
    .WB_DEPTH (WB_DEPTH)
  ) u_wb (
    .clk        (clk),
    .rst        (rst),
    .enq        (enq),
    .enq_addr   (st_addr),
    .enq_wdata  (st_wdata),
    .enq_wmask  (st_wmask),
    .deq        (grant == GNT_WRITE),
    .cmp_word   (ld_req_addr[31:2]),
    .head_addr  (head_addr),
    .head_wdata (head_wdata),
    .head_wmask (head_wmask),
    .full       (wb_full),
    .empty      (wb_empty),
    .count      (wb_count),
    .hz         (hz)
  );

  // Grant selection; a hazarded load never reads, even when the only match is the
  // store entering the buffer this cycle (the port then idles for one cycle).
  always_comb begin
    grant = GNT_IDLE;
    if (!wb_empty && (wb_full || hz || (starve == SW'(STARVE_MAX)))) begin
      grant = GNT_WRITE;
    end else if (ld_req_valid && !hz) begin
      grant = GNT_READ;
    end else if (!wb_empty) begin
      grant = GNT_WRITE;
    end
  end

  // Drive the DM port and the load handshake from the selected grant.
  always_comb begin
    ld_req_ready = 1'b0;
    DM_r_en      = 1'b0;
    DM_addr      = '0;
    DM_w_en      = DM_WMASK_NONE;
    DM_w_data    = '0;
    case (grant)
      GNT_READ: begin
        ld_req_ready = 1'b1;
        DM_r_en      = 1'b1;
        DM_addr      = ld_req_addr;
      end
      GNT_WRITE: begin
        DM_addr   = head_addr;
        DM_w_en   = head_wmask;
        DM_w_data = head_wdata;
      end
      default: ;
    endcase
  end

  // Saturating count of loads granted ahead of a waiting buffered write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if ((grant == GNT_WRITE) || wb_empty) begin
      starve <= '0;
    end else if ((grant == GNT_READ) && (starve != SW'(STARVE_MAX))) begin
      starve <= starve + SW'(1);
    end
  end

  // Read data arrives one cycle after the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_rsp_valid <= 1'b0;
    end else begin
      ld_rsp_valid <= (grant == GNT_READ);
    end
  end

endmodule
